// File: rtl/jtbubl_shared_arb.sv
`default_nettype none
// ============================================================================
//  Module      : jtbubl_shared_arb
//  Description : Shares one single-port 8 KB RAM between the main and sub Z80.
//                Each CPU gets a private port with a wait_n stall line.
//                Accesses are serialised (2 clocks each) with round-robin or
//                fixed main priority on ties. Read data is held per CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtbubl_shared_arb #(
    parameter int AW        = 13,
    parameter int PRIO_MAIN = 0
) (
    input  logic          clk24,
    input  logic          rst,
    // main CPU port
    input  logic          main_cs,
    input  logic          main_we,
    input  logic [AW-1:0] main_addr,
    input  logic [7:0]    main_dout,
    output logic [7:0]    main_din,
    output logic          main_wait_n,
    // sub CPU port
    input  logic          sub_cs,
    input  logic          sub_we,
    input  logic [AW-1:0] sub_addr,
    input  logic [7:0]    sub_dout,
    output logic [7:0]    sub_din,
    output logic          sub_wait_n,
    // shared RAM port
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_q
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACC_MAIN = 2'd1,
        ST_ACC_SUB  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            main_done_q, main_done_d;
    logic            sub_done_q, sub_done_d;
    logic            last_sub_q, last_sub_d;   // 1: sub owned the last access
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [7:0]      ram_din_q, ram_din_d;
    logic            ram_we_q, ram_we_d;
    logic [7:0]      main_din_q, main_din_d;
    logic [7:0]      sub_din_q, sub_din_d;

    logic            main_req, sub_req;
    logic            grant_main, grant_sub;

    // A CPU is pending while it selects the RAM and has not been served yet
    assign main_req = main_cs && !main_done_q;
    assign sub_req  = sub_cs  && !sub_done_q;

    // Stall lines are forced high while reset is held
    assign main_wait_n = rst || !main_req;
    assign sub_wait_n  = rst || !sub_req;

    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_we   = ram_we_q;
    assign main_din = main_din_q;
    assign sub_din  = sub_din_q;

    // Next-state logic: grant selection in IDLE, completion in ACC_x
    always_comb begin
        state_d     = state_q;
        main_done_d = main_done_q;
        sub_done_d  = sub_done_q;
        last_sub_d  = last_sub_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_we_d    = 1'b0;
        main_din_d  = main_din_q;
        sub_din_d   = sub_din_q;
        grant_main  = 1'b0;
        grant_sub   = 1'b0;

        // A served CPU re-arms once it ends its memory cycle
        if (!main_cs) main_done_d = 1'b0;
        if (!sub_cs)  sub_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (main_req && sub_req) begin
                    if ((PRIO_MAIN != 0) || last_sub_q) grant_main = 1'b1;
                    else                                 grant_sub  = 1'b1;
                end else if (main_req) begin
                    grant_main = 1'b1;
                end else if (sub_req) begin
                    grant_sub = 1'b1;
                end

                if (grant_main) begin
                    ram_addr_d = main_addr;
                    ram_din_d  = main_dout;
                    ram_we_d   = main_we;
                    state_d    = ST_ACC_MAIN;
                end else if (grant_sub) begin
                    ram_addr_d = sub_addr;
                    ram_din_d  = sub_dout;
                    ram_we_d   = sub_we;
                    state_d    = ST_ACC_SUB;
                end
            end
            // ram_we_q is still high here only when this access is a write
            ST_ACC_MAIN: begin
                if (!ram_we_q) main_din_d = ram_q;
                main_done_d = 1'b1;
                last_sub_d  = 1'b0;
                state_d     = ST_IDLE;
            end
            ST_ACC_SUB: begin
                if (!ram_we_q) sub_din_d = ram_q;
                sub_done_d = 1'b1;
                last_sub_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            main_done_q <= 1'b0;
            sub_done_q  <= 1'b0;
            last_sub_q  <= 1'b1;
            ram_addr_q  <= '0;
            ram_din_q   <= 8'h00;
            ram_we_q    <= 1'b0;
            main_din_q  <= 8'hFF;
            sub_din_q   <= 8'hFF;
        end else begin
            state_q     <= state_d;
            main_done_q <= main_done_d;
            sub_done_q  <= sub_done_d;
            last_sub_q  <= last_sub_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_we_q    <= ram_we_d;
            main_din_q  <= main_din_d;
            sub_din_q   <= sub_din_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtbubl_shared_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtbubl_shared_arb
//  Description : Self-checking bench for jtbubl_shared_arb: directed vector
//                table, fixed-priority tie sequence, asynchronous reset case
//                and randomized traffic against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtbubl_shared_arb;

    localparam int AW = 13;

    logic          clk24 = 1'b0;
    logic          rst;
    logic          main_cs, main_we, sub_cs, sub_we;
    logic [AW-1:0] main_addr, sub_addr, ram_addr;
    logic [7:0]    main_dout, sub_dout, main_din, sub_din, ram_din, ram_q;
    logic          main_wait_n, sub_wait_n, ram_we;

    // second instance with fixed main priority
    logic          pm_main_cs, pm_sub_cs;
    logic [7:0]    pm_main_din, pm_sub_din, pm_ram_din, pm_ram_q;
    logic [AW-1:0] pm_ram_addr;
    logic          pm_main_wait_n, pm_sub_wait_n, pm_ram_we;
    assign pm_ram_q = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk24 = ~clk24;

    jtbubl_shared_arb #(.AW(AW), .PRIO_MAIN(0)) dut (
        .clk24(clk24), .rst(rst),
        .main_cs(main_cs), .main_we(main_we), .main_addr(main_addr),
        .main_dout(main_dout), .main_din(main_din), .main_wait_n(main_wait_n),
        .sub_cs(sub_cs), .sub_we(sub_we), .sub_addr(sub_addr),
        .sub_dout(sub_dout), .sub_din(sub_din), .sub_wait_n(sub_wait_n),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q)
    );

    jtbubl_shared_arb #(.AW(AW), .PRIO_MAIN(1)) dut_pm (
        .clk24(clk24), .rst(rst),
        .main_cs(pm_main_cs), .main_we(1'b0), .main_addr(13'h0010),
        .main_dout(8'h00), .main_din(pm_main_din), .main_wait_n(pm_main_wait_n),
        .sub_cs(pm_sub_cs), .sub_we(1'b0), .sub_addr(13'h0020),
        .sub_dout(8'h00), .sub_din(pm_sub_din), .sub_wait_n(pm_sub_wait_n),
        .ram_addr(pm_ram_addr), .ram_din(pm_ram_din), .ram_we(pm_ram_we), .ram_q(pm_ram_q)
    );

    // RAM model: write on rising edge, read registered on falling edge
    logic [7:0] ram [0:8191];
    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 8'(i) ^ 8'hA5;
        ram[13'h0123] = 8'h5A;
        forever begin
            @(posedge clk24);
            if (ram_we) ram[ram_addr] = ram_din;
        end
    end
    always @(negedge clk24) ram_q <= ram[ram_addr];

    // ---------------- comparison helpers ----------------
    task automatic report(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic ck1(input string nm, input logic a, input logic e);
        report(nm, 32'(a), 32'(e));
    endtask
    task automatic ck8(input string nm, input logic [7:0] a, input logic [7:0] e);
        report(nm, 32'(a), 32'(e));
    endtask
    task automatic ck13(input string nm, input logic [12:0] a, input logic [12:0] e);
        report(nm, 32'(a), 32'(e));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        mcs, mwe; logic [12:0] maddr; logic [7:0] mdout;
        logic        scs, swe; logic [12:0] saddr; logic [7:0] sdout;
        logic        mw, sw, rwe; logic [12:0] raddr;
        logic [7:0]  rdin, mdin, sdin;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic r,
                       input logic mc, input logic mwv, input logic [12:0] ma, input logic [7:0] md,
                       input logic sc, input logic swv, input logic [12:0] sa, input logic [7:0] sd,
                       input logic emw, input logic esw, input logic erwe, input logic [12:0] era,
                       input logic [7:0] erd, input logic [7:0] emd, input logic [7:0] esd);
        vec_t v;
        v.rst = r; v.mcs = mc; v.mwe = mwv; v.maddr = ma; v.mdout = md;
        v.scs = sc; v.swe = swv; v.saddr = sa; v.sdout = sd;
        v.mw = emw; v.sw = esw; v.rwe = erwe; v.raddr = era;
        v.rdin = erd; v.mdin = emd; v.sdin = esd;
        vq.push_back(v);
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic        cs_v[2], we_v[2];
    logic [12:0] addr_v[2];
    logic [7:0]  dout_v[2];
    int          m_owner;          // -1: RAM free, else CPU whose access is in flight
    bit          m_served[2];      // CPU already served in its current cycle
    int          m_last;           // CPU that completed the most recent access
    logic [7:0]  m_din[2];
    logic [12:0] m_addr;
    logic [7:0]  m_wd;
    bit          m_wr, m_we_out;
    logic [7:0]  m_mem [0:8191];

    function automatic bit pending(input int c);
        return cs_v[c] && !m_served[c];
    endfunction

    // Advance the model across one rising edge using the inputs held before it
    task automatic model_edge();
        bit nxt[2];
        int g;
        for (int c = 0; c < 2; c++) nxt[c] = cs_v[c] ? m_served[c] : 1'b0;
        m_we_out = 1'b0;
        if (m_owner >= 0) begin
            if (m_wr) m_mem[m_addr] = m_wd;
            else      m_din[m_owner] = m_mem[m_addr];
            nxt[m_owner] = 1'b1;
            m_last  = m_owner;
            m_owner = -1;
        end else begin
            g = -1;
            if (pending(0) && pending(1)) g = 1 - m_last;
            else if (pending(0))          g = 0;
            else if (pending(1))          g = 1;
            if (g >= 0) begin
                m_owner  = g;
                m_addr   = addr_v[g];
                m_wd     = dout_v[g];
                m_wr     = we_v[g];
                m_we_out = we_v[g];
            end
        end
        m_served = nxt;
    endtask

    task automatic drive_from_vars();
        main_cs = cs_v[0]; main_we = we_v[0]; main_addr = addr_v[0]; main_dout = dout_v[0];
        sub_cs  = cs_v[1]; sub_we  = we_v[1]; sub_addr  = addr_v[1]; sub_dout  = dout_v[1];
    endtask

    logic tie_m[5];
    logic tie_s[5];

    initial begin
        rst = 1'b1;
        main_cs = 0; main_we = 0; main_addr = '0; main_dout = '0;
        sub_cs = 0;  sub_we = 0;  sub_addr = '0;  sub_dout = '0;
        pm_main_cs = 0; pm_sub_cs = 0;
        tie_m = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tie_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        @(posedge clk24); #1;
        ck1("reset main_wait_n", main_wait_n, 1'b1);
        ck1("reset sub_wait_n", sub_wait_n, 1'b1);
        ck1("reset ram_we", ram_we, 1'b0);
        ck13("reset ram_addr", ram_addr, 13'h0000);
        ck8("reset ram_din", ram_din, 8'h00);
        ck8("reset main_din", main_din, 8'hFF);
        ck8("reset sub_din", sub_din, 8'hFF);

        // rst, main{cs,we,addr,dout}, sub{cs,we,addr,dout}, exp{mw,sw,rwe,raddr,rdin,mdin,sdin}
        add(0, 1,0,13'h0123,8'h00, 0,0,13'h0000,8'h00, 0,1, 0,13'h0123,8'h00,8'hFF,8'hFF); // single read
        add(0, 1,0,13'h0123,8'h00, 0,0,13'h0000,8'h00, 0,1, 0,13'h0123,8'h00,8'h5A,8'hFF);
        add(0, 1,0,13'h0123,8'h00, 0,0,13'h0000,8'h00, 1,1, 0,13'h0123,8'h00,8'h5A,8'hFF);
        add(0, 0,0,13'h0000,8'h00, 0,0,13'h0000,8'h00, 1,1, 0,13'h0123,8'h00,8'h5A,8'hFF);
        add(0, 0,0,13'h0000,8'h00, 1,1,13'h1FFF,8'hC3, 1,0, 1,13'h1FFF,8'hC3,8'h5A,8'hFF); // sub write
        add(0, 0,0,13'h0000,8'h00, 1,1,13'h1FFF,8'hC3, 1,0, 0,13'h1FFF,8'hC3,8'h5A,8'hFF);
        add(0, 0,0,13'h0000,8'h00, 0,0,13'h0000,8'h00, 1,1, 0,13'h1FFF,8'hC3,8'h5A,8'hFF);
        add(0, 1,0,13'h1FFF,8'h00, 0,0,13'h0000,8'h00, 0,1, 0,13'h1FFF,8'h00,8'h5A,8'hFF); // read back
        add(0, 1,0,13'h1FFF,8'h00, 0,0,13'h0000,8'h00, 0,1, 0,13'h1FFF,8'h00,8'hC3,8'hFF);
        add(0, 0,0,13'h0000,8'h00, 0,0,13'h0000,8'h00, 1,1, 0,13'h1FFF,8'h00,8'hC3,8'hFF);
        add(1, 0,0,13'h0000,8'h00, 0,0,13'h0000,8'h00, 1,1, 0,13'h0000,8'h00,8'hFF,8'hFF); // reset
        add(0, 1,0,13'h0123,8'h00, 1,0,13'h1FFF,8'h00, 0,0, 0,13'h0123,8'h00,8'hFF,8'hFF); // tie
        add(0, 1,0,13'h0123,8'h00, 1,0,13'h1FFF,8'h00, 0,0, 0,13'h0123,8'h00,8'h5A,8'hFF);
        add(0, 1,0,13'h0123,8'h00, 1,0,13'h1FFF,8'h00, 1,0, 0,13'h1FFF,8'h00,8'h5A,8'hFF);
        add(0, 1,0,13'h0123,8'h00, 1,0,13'h1FFF,8'h00, 1,0, 0,13'h1FFF,8'h00,8'h5A,8'hC3);
        add(0, 1,1,13'h0AAA,8'hEE, 1,0,13'h1FFF,8'h00, 1,1, 0,13'h1FFF,8'h00,8'h5A,8'hC3); // held cs ignored
        add(0, 0,0,13'h0000,8'h00, 0,0,13'h0000,8'h00, 1,1, 0,13'h1FFF,8'h00,8'h5A,8'hC3);
        add(0, 1,0,13'h0123,8'h00, 0,0,13'h0000,8'h00, 0,1, 0,13'h0123,8'h00,8'h5A,8'hC3); // main only
        add(0, 1,0,13'h0123,8'h00, 0,0,13'h0000,8'h00, 0,1, 0,13'h0123,8'h00,8'h5A,8'hC3);
        add(0, 0,0,13'h0000,8'h00, 0,0,13'h0000,8'h00, 1,1, 0,13'h0123,8'h00,8'h5A,8'hC3);
        add(0, 1,0,13'h0123,8'h00, 1,0,13'h1FFF,8'h00, 0,0, 0,13'h1FFF,8'h00,8'h5A,8'hC3); // tie: sub first
        add(0, 1,0,13'h0123,8'h00, 1,0,13'h1FFF,8'h00, 0,0, 0,13'h1FFF,8'h00,8'h5A,8'hC3);
        add(0, 1,0,13'h0123,8'h00, 1,0,13'h1FFF,8'h00, 0,1, 0,13'h0123,8'h00,8'h5A,8'hC3);
        add(0, 1,0,13'h0123,8'h00, 1,0,13'h1FFF,8'h00, 0,1, 0,13'h0123,8'h00,8'h5A,8'hC3);
        add(0, 1,0,13'h0123,8'h00, 1,0,13'h1FFF,8'h00, 1,1, 0,13'h0123,8'h00,8'h5A,8'hC3);
        add(0, 0,0,13'h0000,8'h00, 0,0,13'h0000,8'h00, 1,1, 0,13'h0123,8'h00,8'h5A,8'hC3);
        add(0, 1,1,13'h0456,8'h77, 0,0,13'h0000,8'h00, 0,1, 1,13'h0456,8'h77,8'h5A,8'hC3); // cs drops early
        add(0, 0,0,13'h0000,8'h00, 1,0,13'h0456,8'h00, 1,0, 0,13'h0456,8'h77,8'h5A,8'hC3);
        add(0, 0,0,13'h0000,8'h00, 1,0,13'h0456,8'h00, 1,0, 0,13'h0456,8'h00,8'h5A,8'hC3);
        add(0, 0,0,13'h0000,8'h00, 1,0,13'h0456,8'h00, 1,0, 0,13'h0456,8'h00,8'h5A,8'h77);
        add(0, 0,0,13'h0000,8'h00, 0,0,13'h0000,8'h00, 1,1, 0,13'h0456,8'h00,8'h5A,8'h77);

        foreach (vq[i]) begin
            rst = vq[i].rst;
            main_cs = vq[i].mcs; main_we = vq[i].mwe; main_addr = vq[i].maddr; main_dout = vq[i].mdout;
            sub_cs  = vq[i].scs; sub_we  = vq[i].swe; sub_addr  = vq[i].saddr; sub_dout  = vq[i].sdout;
            #2;
            ck1($sformatf("row%0d main_wait_n", i), main_wait_n, vq[i].mw);
            ck1($sformatf("row%0d sub_wait_n", i), sub_wait_n, vq[i].sw);
            @(posedge clk24); #1;
            ck1($sformatf("row%0d ram_we", i), ram_we, vq[i].rwe);
            ck13($sformatf("row%0d ram_addr", i), ram_addr, vq[i].raddr);
            ck8($sformatf("row%0d ram_din", i), ram_din, vq[i].rdin);
            ck8($sformatf("row%0d main_din", i), main_din, vq[i].mdin);
            ck8($sformatf("row%0d sub_din", i), sub_din, vq[i].sdin);
        end

        // Fixed main priority: a tie right after a main-only access still goes to main
        for (int it = 0; it < 3; it++) begin
            pm_main_cs = 1'b1;
            for (int c = 0; c < 3; c++) begin
                #2;
                ck1($sformatf("prio it%0d solo c%0d main_wait_n", it, c), pm_main_wait_n, (c == 2));
                @(posedge clk24); #1;
            end
            pm_main_cs = 1'b0;
            @(posedge clk24); #1;
            pm_main_cs = 1'b1; pm_sub_cs = 1'b1;
            for (int c = 0; c < 5; c++) begin
                #2;
                ck1($sformatf("prio it%0d tie c%0d main_wait_n", it, c), pm_main_wait_n, tie_m[c]);
                ck1($sformatf("prio it%0d tie c%0d sub_wait_n", it, c), pm_sub_wait_n, tie_s[c]);
                @(posedge clk24); #1;
            end
            pm_main_cs = 1'b0; pm_sub_cs = 1'b0;
            @(posedge clk24); #1;
        end

        // Randomized traffic against the model
        main_cs = 0; sub_cs = 0; rst = 1'b1;
        @(posedge clk24); #1;
        rst = 1'b0;
        for (int i = 0; i < 8192; i++) m_mem[i] = ram[i];
        m_owner = -1; m_last = 1; m_served = '{1'b0, 1'b0};
        m_din = '{8'hFF, 8'hFF}; m_addr = '0; m_wd = '0; m_wr = 1'b0; m_we_out = 1'b0;
        cs_v = '{1'b0, 1'b0}; we_v = '{1'b0, 1'b0};
        addr_v = '{13'h0, 13'h0}; dout_v = '{8'h0, 8'h0};
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                int a;
                a = int'($urandom_range(0, 8));
                if (!cs_v[c]) begin
                    if ($urandom_range(0, 9) < 4) begin
                        cs_v[c]   = 1'b1;
                        we_v[c]   = 1'($urandom_range(0, 1));
                        addr_v[c] = (a == 8) ? 13'h1FFF : 13'(a);
                        dout_v[c] = 8'($urandom);
                    end
                end else if (!pending(c)) begin
                    if ($urandom_range(0, 1) == 1) cs_v[c] = 1'b0;
                    else begin
                        we_v[c]   = 1'($urandom_range(0, 1));
                        addr_v[c] = (a == 8) ? 13'h1FFF : 13'(a);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    cs_v[c] = 1'b0;
                end
            end
            drive_from_vars();
            #2;
            ck1($sformatf("rnd%0d main_wait_n", cyc), main_wait_n, !pending(0));
            ck1($sformatf("rnd%0d sub_wait_n", cyc), sub_wait_n, !pending(1));
            @(posedge clk24);
            model_edge();
            #1;
            ck1($sformatf("rnd%0d ram_we", cyc), ram_we, m_we_out);
            ck13($sformatf("rnd%0d ram_addr", cyc), ram_addr, m_addr);
            ck8($sformatf("rnd%0d ram_din", cyc), ram_din, m_wd);
            ck8($sformatf("rnd%0d main_din", cyc), main_din, m_din[0]);
            ck8($sformatf("rnd%0d sub_din", cyc), sub_din, m_din[1]);
        end

        // Asynchronous reset in the middle of a main access
        main_cs = 0; sub_cs = 0;
        repeat (3) @(posedge clk24);
        #1;
        main_cs = 1'b1; main_we = 1'b0; main_addr = 13'h0123; main_dout = 8'h00;
        @(posedge clk24); #1;
        ck13("arst grant ram_addr", ram_addr, 13'h0123);
        #1 rst = 1'b1;
        #1;
        ck13("arst ram_addr", ram_addr, 13'h0000);
        ck8("arst ram_din", ram_din, 8'h00);
        ck1("arst ram_we", ram_we, 1'b0);
        ck8("arst main_din", main_din, 8'hFF);
        ck8("arst sub_din", sub_din, 8'hFF);
        ck1("arst main_wait_n", main_wait_n, 1'b1);
        ck1("arst sub_wait_n", sub_wait_n, 1'b1);
        @(posedge clk24); #1;
        rst = 1'b0;
        #1 ck1("post-rst c1 main_wait_n", main_wait_n, 1'b0);
        @(posedge clk24); #1;
        ck13("post-rst grant ram_addr", ram_addr, 13'h0123);
        #1 ck1("post-rst c2 main_wait_n", main_wait_n, 1'b0);
        @(posedge clk24); #1;
        ck8("post-rst main_din", main_din, 8'h5A);
        #1 ck1("post-rst c3 main_wait_n", main_wait_n, 1'b1);
        main_cs = 1'b0;
        @(posedge clk24); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
